// File: rtl/line_buffer_3x3.sv
// line_buffer_3x3
// Purpose: turns a raster-order pixel stream into a sliding 3x3 pixel
//          neighbourhood. Two row-length line buffers delay the stream by one
//          and two rows. A 3x3 register window shifts left by one column on
//          every accepted pixel. Only windows lying fully inside the frame
//          (no padding) are flagged valid.
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   data_i        raster-order pixel, sampled when valid_i=1
//   valid_i       pixel qualifier; low means stall (everything holds)
//   window_o      registered 3x3 window, pixel(r-2+i, c-2+j) at (3*i+j)*WIDTH
//   valid_o       one-cycle pulse when window_o holds a complete window
//   frame_done_o  one-cycle pulse after the last pixel of a frame
module line_buffer_3x3 #(
  parameter int WIDTH = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     data_i,
  input  logic                 valid_i,
  output logic [9*WIDTH-1:0]   window_o,
  output logic                 valid_o,
  output logic                 frame_done_o
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] C_TWO  = CW'(2);
  localparam logic [RW-1:0] R_TWO  = RW'(2);

  logic [CW-1:0]        c_q, c_d;
  logic [RW-1:0]        r_q, r_d;
  logic [9*WIDTH-1:0]   win_q, win_d;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;

  // lb1 holds row r-1 and lb2 holds row r-2, both indexed by column.
  logic [WIDTH-1:0]     lb1_mem_q [IMG_W];
  logic [WIDTH-1:0]     lb2_mem_q [IMG_W];
  logic [WIDTH-1:0]     lb1_rd_s;
  logic [WIDTH-1:0]     lb2_rd_s;

  // Asynchronous reads give the pre-write contents because the writes are
  // non-blocking. A same-address read and write therefore sees the old data.
  assign lb1_rd_s = lb1_mem_q[c_q];
  assign lb2_rd_s = lb2_mem_q[c_q];

  // Next-state logic for the counters, the window and the output pulses.
  always_comb begin
    c_d     = c_q;
    r_d     = r_q;
    win_d   = win_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    if (valid_i) begin
      if (c_q == C_LAST) begin
        c_d = '0;
        if (r_q == R_LAST) begin
          r_d = '0;
        end else begin
          r_d = r_q + RW'(1);
        end
      end else begin
        c_d = c_q + CW'(1);
      end
      // Each window row shifts left; the freshly read column enters at j=2.
      for (int i = 0; i < 3; i++) begin
        win_d[(3*i)*WIDTH   +: WIDTH] = win_q[(3*i+1)*WIDTH +: WIDTH];
        win_d[(3*i+1)*WIDTH +: WIDTH] = win_q[(3*i+2)*WIDTH +: WIDTH];
      end
      win_d[2*WIDTH +: WIDTH] = lb2_rd_s;
      win_d[5*WIDTH +: WIDTH] = lb1_rd_s;
      win_d[8*WIDTH +: WIDTH] = data_i;
      // The r>=2 and c>=2 tests exclude stale line-buffer rows and columns
      // that wrapped in from the previous row.
      valid_d = (r_q >= R_TWO) && (c_q >= C_TWO);
      done_d  = (r_q == R_LAST) && (c_q == C_LAST);
    end else begin
      valid_d = 1'b0;
      done_d  = 1'b0;
    end
  end

  // Control and window registers; an asynchronous reset clears the frame position and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q     <= '0;
      r_q     <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      c_q     <= c_d;
      r_q     <= r_d;
      win_q   <= win_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Line buffers cascade row r into lb1 and row r-1 into lb2; reset leaves them untouched.
  always_ff @(posedge clk) begin
    if (valid_i) begin
      lb1_mem_q[c_q] <= data_i;
      lb2_mem_q[c_q] <= lb1_rd_s;
    end
  end

  assign window_o     = win_q;
  assign valid_o      = valid_q;
  assign frame_done_o = done_q;

endmodule

// File: tb/tb_line_buffer_3x3.sv
// Testbench for line_buffer_3x3 (IMG_W=5, IMG_H=4, WIDTH=8).
// A reference model stores every accepted pixel by its (row, col) position in
// the frame. For each accepted pixel, the model predicts valid_o, frame_done_o
// and the 3x3 neighbourhood directly from that stored image.
module tb_line_buffer_3x3;
  localparam int WIDTH = 8;
  localparam int IMG_W = 5;
  localparam int IMG_H = 4;
  localparam int NPIX  = IMG_W * IMG_H;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [WIDTH-1:0]   data_i = '0;
  logic               valid_i = 1'b0;
  logic [9*WIDTH-1:0] window_o;
  logic               valid_o;
  logic               frame_done_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int               mpos = 0;
  logic [WIDTH-1:0] img [IMG_H][IMG_W];
  int               frame_valid_cnt = 0;
  int               done_cnt = 0;
  logic [9*WIDTH-1:0] seen_wins [$];
  logic [9*WIDTH-1:0] done_win;

  always #5 clk = ~clk;

  line_buffer_3x3 #(.WIDTH(WIDTH), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_i       (data_i),
    .valid_i      (valid_i),
    .window_o     (window_o),
    .valid_o      (valid_o),
    .frame_done_o (frame_done_o)
  );

  function automatic logic [9*WIDTH-1:0] win9(input int p0, input int p1, input int p2,
                                              input int p3, input int p4, input int p5,
                                              input int p6, input int p7, input int p8);
    logic [9*WIDTH-1:0] w;
    w = {WIDTH'(p8), WIDTH'(p7), WIDTH'(p6), WIDTH'(p5), WIDTH'(p4),
         WIDTH'(p3), WIDTH'(p2), WIDTH'(p1), WIDTH'(p0)};
    return w;
  endfunction

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_win(input string tag, input logic [9*WIDTH-1:0] obs,
                         input logic [9*WIDTH-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, advance the model, and check the outputs.
  task automatic step(input logic v, input logic [WIDTH-1:0] d);
    int r;
    int c;
    logic exp_v;
    logic exp_d;
    logic [9*WIDTH-1:0] exp_w;
    @(negedge clk);
    valid_i = v;
    data_i  = d;
    r = mpos / IMG_W;
    c = mpos % IMG_W;
    exp_v = v && (r >= 2) && (c >= 2);
    exp_d = v && (mpos == NPIX - 1);
    exp_w = '0;
    if (v) begin
      img[r][c] = d;
      mpos = (mpos + 1) % NPIX;
    end
    if (exp_v) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          exp_w[(3*i+j)*WIDTH +: WIDTH] = img[r-2+i][c-2+j];
    end
    @(posedge clk);
    #1;
    chk_bit("valid_o", valid_o, exp_v);
    chk_bit("frame_done_o", frame_done_o, exp_d);
    if (exp_v) begin
      chk_win("window_o", window_o, exp_w);
    end
    if (valid_o) begin
      frame_valid_cnt++;
      seen_wins.push_back(window_o);
    end
    if (frame_done_o) begin
      done_cnt++;
      done_win = window_o;
    end
  endtask

  // Sends one whole frame with optional idle gaps (bounded to 3 per pixel).
  task automatic run_frame(input int base, input int idle_pct, input bit rnd_pix);
    int k;
    logic [WIDTH-1:0] px;
    for (int p = 0; p < NPIX; p++) begin
      k = 0;
      while ((k < 3) && (int'($urandom_range(99)) < idle_pct)) begin
        step(1'b0, WIDTH'($urandom));
        k++;
      end
      px = rnd_pix ? WIDTH'($urandom) : WIDTH'(base + 5 * (p / IMG_W) + (p % IMG_W));
      step(1'b1, px);
    end
  endtask

  task automatic check_ref_frame(input string tag);
    chk_int({tag, "_pulses"}, frame_valid_cnt, 6);
    if (seen_wins.size() == 6) begin
      chk_win({tag, "_first"}, seen_wins[0], win9(0, 1, 2, 5, 6, 7, 10, 11, 12));
      chk_win({tag, "_row_end"}, seen_wins[2], win9(2, 3, 4, 7, 8, 9, 12, 13, 14));
      chk_win({tag, "_after_wrap"}, seen_wins[3], win9(5, 6, 7, 10, 11, 12, 15, 16, 17));
      chk_win({tag, "_last"}, seen_wins[5], win9(7, 8, 9, 12, 13, 14, 17, 18, 19));
    end else begin
      chk_int({tag, "_win_count"}, seen_wins.size(), 6);
    end
    chk_win({tag, "_done_win"}, done_win, win9(7, 8, 9, 12, 13, 14, 17, 18, 19));
  endtask

  initial begin
    // Reset state
    #12;
    chk_bit("rst_valid_o", valid_o, 1'b0);
    chk_bit("rst_frame_done_o", frame_done_o, 1'b0);
    chk_win("rst_window_o", window_o, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Continuous frame, pixel = 5r+c
    frame_valid_cnt = 0; seen_wins.delete(); done_cnt = 0;
    run_frame(0, 0, 1'b0);
    step(1'b0, '0);
    check_ref_frame("cont");
    chk_int("cont_done_cnt", done_cnt, 1);

    // Same frame with ~30% idle gaps
    frame_valid_cnt = 0; seen_wins.delete();
    run_frame(0, 30, 1'b0);
    step(1'b0, '0);
    check_ref_frame("gaps");

    // Random pixel data with gaps, checked against the model only
    frame_valid_cnt = 0; seen_wins.delete();
    run_frame(0, 30, 1'b1);
    chk_int("rnd_pulses", frame_valid_cnt, 6);

    // Mid-frame reset after pixel 9
    for (int p = 0; p < 10; p++) step(1'b1, WIDTH'(p));
    @(negedge clk);
    valid_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_bit("midrst_valid_o", valid_o, 1'b0);
    chk_bit("midrst_frame_done_o", frame_done_o, 1'b0);
    chk_win("midrst_window_o", window_o, '0);
    @(negedge clk);
    rst_n = 1'b1;
    mpos = 0;
    frame_valid_cnt = 0; seen_wins.delete(); done_cnt = 0;
    run_frame(0, 0, 1'b0);
    step(1'b0, '0);
    check_ref_frame("restart");
    chk_int("restart_done_cnt", done_cnt, 1);

    // Two frames back-to-back, second one offset by 100
    done_cnt = 0;
    run_frame(0, 0, 1'b0);
    frame_valid_cnt = 0; seen_wins.delete();
    run_frame(100, 0, 1'b0);
    step(1'b0, '0);
    chk_int("b2b_pulses", frame_valid_cnt, 6);
    if (seen_wins.size() > 0) begin
      chk_win("b2b_first", seen_wins[0], win9(100, 101, 102, 105, 106, 107, 110, 111, 112));
    end else begin
      chk_int("b2b_win_count", seen_wins.size(), 6);
    end
    for (int w = 0; w < seen_wins.size(); w++) begin
      for (int k = 0; k < 9; k++) begin
        chk_bit("b2b_no_stale", (seen_wins[w][k*WIDTH +: WIDTH] >= 8'd100), 1'b1);
      end
    end
    chk_int("b2b_done_cnt", done_cnt, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/line_buffer_3x3.md
LINE_BUFFER_3X3 -- requirements
Module: line_buffer_3x3

Interface
REQ-001 Parameter WIDTH, 8, pixel bit width.
REQ-002 Parameter IMG_W, 640, pixels per row; legal range 3..4096.
REQ-003 Parameter IMG_H, 480, rows per frame; legal range 3..4096.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 data_i  input  WIDTH  raster-order pixel; sampled only when valid_i=1.
REQ-007 valid_i  input  1  qualifies data_i; may deassert on any cycle (stall).
REQ-008 window_o  output  9*WIDTH  3x3 window, registered.
REQ-009 valid_o  output  1  window_o holds a complete in-frame window; one-cycle pulse per window.
REQ-010 frame_done_o  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-011 The block SHALL keep column counter c (0..IMG_W-1) and row counter r (0..IMG_H-1), both advanced only on accepted pixels (valid_i=1).
- c wraps IMG_W-1 -> 0 and increments r.
- r wraps IMG_H-1 -> 0 together with c.
REQ-012 The block SHALL hold two line buffers of IMG_W entries each, addressed by c, delaying data_i by one and two rows; a read and a write at the same address in one cycle SHALL return the old contents.
REQ-013 The block SHALL hold a 3x3 register window; each accepted pixel shifts every window row left by one column and loads the new column as (row r-2, row r-1, data_i).
REQ-014 Window layout: pixel(r-2+i, c-2+j), i,j in 0..2, SHALL appear at window_o[(3*i+j)*WIDTH +: WIDTH], so bits [8*WIDTH +: WIDTH] hold the newest pixel.
REQ-015 valid_o SHALL assert exactly one cycle after an accepted pixel with r>=2 and c>=2, and SHALL be 0 otherwise.
- No padding: (IMG_H-2)*(IMG_W-2) windows per frame.
REQ-016 Latency: window_o and valid_o SHALL update on the edge after the pixel completing the window is accepted (1 cycle).
REQ-017 With valid_i=0, counters, line buffers and window_o SHALL hold, and valid_o SHALL be 0.
REQ-018 frame_done_o SHALL pulse one cycle after the pixel at r=IMG_H-1, c=IMG_W-1 is accepted, in the same cycle as the final valid_o.
REQ-019 Back-to-back frames: a pixel accepted in the cycle after the last pixel of a frame SHALL be treated as r=0, c=0 of the next frame.
- Stale line-buffer data SHALL never reach a valid_o window, since r<2 suppresses it.
REQ-020 Window columns that carry data from the previous row after a row wrap SHALL never be flagged valid (guaranteed by c>=2).

Reset
REQ-021 With rst_n=0, asynchronously: c=0, r=0, window_o=0, valid_o=0, frame_done_o=0.
REQ-022 Line-buffer contents need not be cleared by reset.
REQ-023 After rst_n deasserts, the first accepted pixel SHALL be r=0, c=0.
REQ-024 Reset mid-frame SHALL discard the partial frame; no valid_o or frame_done_o SHALL be produced for it.

Verification (IMG_W=5, IMG_H=4, WIDTH=8, pixel = 5r+c)
REQ-025 Continuous valid_i, one frame:
- First valid_o is the cycle after pixel 12.
- window_o from index 0 to 8 = 0,1,2,5,6,7,10,11,12.
- Exactly 6 valid_o pulses in total.
- frame_done_o coincides with the last pulse, window = 7,8,9,12,13,14,17,18,19.
REQ-026 Random valid_i gaps (30% idle) over the same frame -> identical 6 windows in the same order; valid_o never asserts in a cycle following an idle cycle.
REQ-027 Row wrap -> the window ending at (2,4) is followed by the window ending at (3,2) = 5,6,7,10,11,12,15,16,17, with no valid_o for (3,0) or (3,1).
REQ-028 rst_n pulsed low after pixel 9 -> all outputs 0 immediately; a restarted full frame reproduces REQ-025 exactly.
REQ-029 Two frames back-to-back, second frame pixel = 100+5r+c:
- First window of frame 2 = 100,101,102,105,106,107,110,111,112.
- No frame-1 values appear in any frame-2 window.
- frame_done_o pulses exactly twice.
